// File: rtl/aes_inv_rounddata_seq_if.sv
// Handshake and data bus of the iterative AES decrypt datapath.
// The master side supplies ciphertext, round keys and output backpressure.
// The slave side is the datapath itself.
`timescale 1ns/1ps
interface aes_inv_rounddata_seq_if;
   logic [1:0]   mode;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] data_in;
   logic [3:0]   key_round;
   logic [127:0] round_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;
   logic         busy;

   modport master (
      output mode, in_valid, data_in, round_key, out_ready,
      input  in_ready, key_round, out_valid, data_out, busy
   );

   modport slave (
      input  mode, in_valid, data_in, round_key, out_ready,
      output in_ready, key_round, out_valid, data_out, busy
   );
endinterface

// File: rtl/aes_inv_rounddata_seq.sv
// Iterative AES inverse cipher, one 32-bit column per clock.
// Each column step applies InvShiftRows, InvSubBytes, AddRoundKey and
// InvMixColumns. InvMixColumns is skipped in the last round.
// Round keys are fetched by index from an external store, highest index first.
`timescale 1ns/1ps
package aes_inv_gf_pkg;
   // Multiply by x in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply using shift-and-add.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254.
   // a^254 = a^2 * a^4 * ... * a^128. An input of zero maps to zero.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction
endpackage

// Inverse S-box applied to the four bytes of a word.
// It undoes the affine transform first, then takes the field inverse.
module aes_inv_sbox_word (
   input  logic [31:0] word,
   output logic [31:0] result
);
   import aes_inv_gf_pkg::*;

   function automatic logic [7:0] inv_affine(input logic [7:0] y);
      return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign result[8*gi +: 8] = gf_inv(inv_affine(word[8*gi +: 8]));
   end
endmodule

// InvMixColumns on one column, with byte 0 held in the MSB.
// Each output row is a rotation of the coefficients {0e,0b,0d,09}.
module aes_inv_mixword (
   input  logic [31:0] word,
   output logic [31:0] result
);
   import aes_inv_gf_pkg::*;

   logic [7:0] a [0:3];

   for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      assign a[gi] = word[31-8*gi -: 8];
      assign result[31-8*gi -: 8] = gf_mul(a[gi], 8'h0e)
                                  ^ gf_mul(a[(gi+1)%4], 8'h0b)
                                  ^ gf_mul(a[(gi+2)%4], 8'h0d)
                                  ^ gf_mul(a[(gi+3)%4], 8'h09);
   end
endmodule

module aes_inv_rounddata_seq (
   input  logic                    clk,
   input  logic                    rst_n,
   aes_inv_rounddata_seq_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} fsm_t;

   fsm_t         fsm_reg;
   logic [127:0] state_reg;    // round input, read-only while a round runs
   logic [127:0] next_reg;     // round output, filled one column at a time
   logic [127:0] data_out_reg;
   logic [3:0]   nr_reg;
   logic [3:0]   rnd_reg;
   logic [1:0]   col_reg;
   logic         in_ready_reg;
   logic         out_valid_reg;
   logic         busy_reg;

   logic [31:0]  shifted_col;
   logic [31:0]  sub_col;
   logic [31:0]  added_col;
   logic [31:0]  mixed_col;
   logic [31:0]  result_col;
   logic [3:0]   nr_sel;
   logic [3:0]   key_round_sel;

   // InvShiftRows for the current column only.
   // Row i is taken from column (col - i) mod 4 of the full state.
   for (genvar gi = 0; gi < 4; gi++) begin : g_shift
      logic [1:0] src_col;
      assign src_col = col_reg - 2'(gi);
      assign shifted_col[31-8*gi -: 8] = state_reg[127 - 32*int'(src_col) - 8*gi -: 8];
   end

   aes_inv_sbox_word u_sbox (
      .word   (shifted_col),
      .result (sub_col)
   );

   assign added_col = sub_col ^ bus.round_key[127 - 32*int'(col_reg) -: 32];

   aes_inv_mixword u_mix (
      .word   (added_col),
      .result (mixed_col)
   );

   assign result_col = (rnd_reg == 4'd0) ? added_col : mixed_col;

   // Mode 11 falls back to the AES-256 round count.
   always_comb begin
      nr_sel = 4'd14;
      case (bus.mode)
         2'b00:   nr_sel = 4'd10;
         2'b01:   nr_sel = 4'd12;
         default: nr_sel = 4'd14;
      endcase
   end

   // Key index requested from the external store, decoded from the FSM state.
   always_comb begin
      key_round_sel = 4'd0;
      case (fsm_reg)
         INIT:    key_round_sel = nr_reg;
         ROUND:   key_round_sel = rnd_reg;
         default: key_round_sel = 4'd0;
      endcase
   end

   // Control FSM and datapath registers; the outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_reg       <= IDLE;
         state_reg     <= '0;
         next_reg      <= '0;
         data_out_reg  <= '0;
         nr_reg        <= '0;
         rnd_reg       <= '0;
         col_reg       <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (fsm_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  state_reg    <= bus.data_in;
                  nr_reg       <= nr_sel;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  fsm_reg      <= INIT;
               end
            end
            INIT: begin
               state_reg <= state_reg ^ bus.round_key;
               rnd_reg   <= nr_reg - 4'd1;
               col_reg   <= 2'd0;
               fsm_reg   <= ROUND;
            end
            ROUND: begin
               next_reg[127 - 32*int'(col_reg) -: 32] <= result_col;
               col_reg <= col_reg + 2'd1;
               if (col_reg == 2'd3) begin
                  state_reg <= {next_reg[127:32], result_col};
                  if (rnd_reg == 4'd0) begin
                     data_out_reg  <= {next_reg[127:32], result_col};
                     out_valid_reg <= 1'b1;
                     busy_reg      <= 1'b0;
                     fsm_reg       <= DONE;
                  end else begin
                     rnd_reg <= rnd_reg - 4'd1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  fsm_reg       <= IDLE;
               end
            end
            default: fsm_reg <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.data_out  = data_out_reg;
   assign bus.busy      = busy_reg;
   assign bus.key_round = key_round_sel;
endmodule

// File: tb/tb_aes_inv_rounddata_seq.sv
// Directed bench for aes_inv_rounddata_seq using FIPS-197 vectors.
// The key store is expanded inside the bench.
// Expected plaintexts go through a queue that is popped when out_valid rises.
`timescale 1ns/1ps
module tb_aes_inv_rounddata_seq;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   aes_inv_rounddata_seq_if bus();

   aes_inv_rounddata_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [127:0] rk [0:15];
   assign bus.round_key = rk[bus.key_round];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int acc_cyc = 0;
   logic [127:0] sb_q [$];

   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

   function automatic logic [7:0] m_xtime(input logic [7:0] a);
      return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = m_xtime(x);
      end
      return p;
   endfunction

   // Forward S-box: field inverse by search, then the affine transform.
   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [7:0] s = 8'h00;
      for (int b = 1; b < 256; b++)
         if (x != 8'h00 && m_mul(x, 8'(b)) == 8'h01) s = 8'(b);
      return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] m_subword(input logic [31:0] w);
      return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
   endfunction

   // Fills the external key store with the expanded key.
   task automatic load_keys(input logic [255:0] key, input int nk);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      int nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = m_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = m_xtime(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = m_subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents a block and pushes its expected plaintext to the scoreboard.
   task automatic drive(input logic [1:0] m, input logic [127:0] ct, input logic [127:0] pt);
      bus.mode     = m;
      bus.data_in  = ct;
      bus.in_valid = 1'b1;
      sb_q.push_back(pt);
   endtask

   // Waits for in_ready, then records the accept edge.
   task automatic accept(input bit hold);
      int n = 0;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("accept_timeout", 128'(n), 128'd0);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!hold) bus.in_valid = 1'b0;
   endtask

   // Waits for out_valid within a bounded number of cycles.
   // It then checks the latency and the plaintext against the scoreboard.
   task automatic wait_out(input int exp_lat, input bit chk_keys, input bit toggle, input string tag);
      int  n = 0;
      bit  seen = 1'b0;
      int  exp_kr;
      logic [127:0] exp_pt;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         n = cyc - acc_cyc;
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         if (chk_keys) begin
            exp_kr = (n == 0) ? 10 : 9 - (n - 1) / 4;
            chk({tag, "_key_round"}, 128'(bus.key_round), 128'(exp_kr));
         end
         if (toggle) begin
            bus.mode    = 2'($urandom_range(0, 3));
            bus.data_in = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      chk({tag, "_out_valid_seen"}, 128'(seen), 128'd1);
      if (seen) begin
         chk({tag, "_latency"}, 128'(n), 128'(exp_lat));
         exp_pt = (sb_q.size() > 0) ? sb_q.pop_front() : 128'hx;
         chk({tag, "_data_out"}, bus.data_out, exp_pt);
      end
   endtask

   initial begin
      int a_acc;
      bus.in_valid  = 1'b0;
      bus.mode      = 2'b00;
      bus.data_in   = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      load_keys(K128, 4);
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_busy",      128'(bus.busy),      128'd0);
      chk("rst_data_out",  bus.data_out,        128'd0);
      chk("rst_key_round", 128'(bus.key_round), 128'd0);
      rst_n = 1'b1;

      // AES-128 with the full key_round sequence
      @(negedge clk);
      drive(2'b00, CT128, PT);
      accept(1'b0);
      wait_out(41, 1'b1, 1'b0, "aes128");

      // AES-192
      @(negedge clk);
      load_keys(K192, 6);
      drive(2'b01, CT192, PT);
      accept(1'b0);
      wait_out(49, 1'b0, 1'b0, "aes192");

      // AES-256, then mode 11
      @(negedge clk);
      load_keys(K256, 8);
      drive(2'b10, CT256, PT);
      accept(1'b0);
      wait_out(57, 1'b0, 1'b0, "aes256");
      @(negedge clk);
      drive(2'b11, CT256, PT);
      accept(1'b0);
      wait_out(57, 1'b0, 1'b0, "mode11");

      // Backpressure with in_valid held high throughout
      @(negedge clk);
      load_keys(K128, 4);
      bus.out_ready = 1'b0;
      drive(2'b00, CT128, PT);
      accept(1'b1);
      wait_out(41, 1'b0, 1'b0, "bp_first");
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
         chk("bp_in_ready",  128'(bus.in_ready),  128'd0);
         chk("bp_data_out",  bus.data_out,        PT);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
      chk("bp_release_in_ready",  128'(bus.in_ready),  128'd1);
      sb_q.push_back(PT);
      accept(1'b0);
      wait_out(41, 1'b0, 1'b0, "bp_second");
      bus.out_ready = 1'b1;
      @(negedge clk);

      // Asynchronous reset during round 5, column 2
      @(negedge clk);
      drive(2'b00, CT128, PT);
      accept(1'b0);
      repeat (20) @(negedge clk);
      chk("midrst_key_round_before", 128'(bus.key_round), 128'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready",  128'(bus.in_ready),  128'd1);
      chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("midrst_data_out",  bus.data_out,        128'd0);
      chk("midrst_key_round", 128'(bus.key_round), 128'd0);
      chk("midrst_busy",      128'(bus.busy),      128'd0);
      void'(sb_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(2'b00, CT128, PT);
      accept(1'b0);
      wait_out(41, 1'b0, 1'b0, "after_rst");

      // Back-to-back blocks; mode and data_in are scrambled while busy
      @(negedge clk);
      drive(2'b00, CT128, PT);
      accept(1'b1);
      a_acc = acc_cyc;
      wait_out(41, 1'b0, 1'b1, "b2b_a");
      load_keys(KB, 4);
      drive(2'b00, CTB, PTB);
      accept(1'b0);
      chk("b2b_spacing", 128'(acc_cyc - a_acc), 128'd43);
      wait_out(41, 1'b0, 1'b0, "b2b_b");

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
